back_scan_gen: RTL and testbench
================================

# back_scan_gen

Scan generator that sits directly upstream of the background colour stage. It produces VGA sync, the active-video `blank` flag, screen coordinates and the 15-bit background ROM address for a 160×120 image scaled ×4 to 640×480. It supports a per-frame horizontal scroll offset with wrap-around. All outputs are registered and aligned so the downstream colour stage can register RGB one cycle later with matching sync.

## Interface
- H_VISIBLE, 640: visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal porch and sync widths; line = 800 clocks
- V_VISIBLE, 480: visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porch and sync widths; frame = 525 lines
- IMG_W / IMG_H, 160 / 120: background image size in texels
- SCALE_SHIFT, 2: log2 of the pixel-per-texel scale
- ADDR_W, 15: ROM address width
- vga_clk  in  1  pixel clock (25 MHz); all logic on posedge
- reset  in  1  asynchronous, active-high
- scroll_x  in  8  horizontal texel offset, sampled once per frame
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  1 = visible pixel (colour stage drives RGB only when 1)
- drawX  out  10  current pixel column
- drawY  out  10  current pixel line
- rom_address  out  ADDR_W  background texel address for (drawX, drawY)
- frame_start  out  1  one-cycle pulse with pixel (0,0)

## Operation
- Counters: hc 0..799 increments every clock and wraps to 0. vc increments when hc wraps, range 0..524, and wraps to 0.
- Output stage registers drawX = hc and drawY = vc.
  - blank = (hc < 640) && (vc < 480).
  - frame_start = (hc == 0 && vc == 0).
- Scroll latch: on the clock where the counters wrap to (0,0), latch scroll_x into scroll_q if scroll_x < IMG_W. Otherwise scroll_q keeps its previous value. Mid-frame changes of scroll_x have no effect.
- Address, no multiplier:
  - row_base resets to 0 at vc wrap.
  - row_base += IMG_W on each line transition where (vc+1) mod 4 == 0 and vc < 479.
  - col = ((hc >> 2) + scroll_q). If col ≥ IMG_W, subtract IMG_W. The sum is 9-bit; a single conditional subtract suffices because both operands are < 160.
  - rom_address = blank ? row_base + col : 0.
- Syncs:
  - hs_raw = !(656 ≤ hc < 752); vs_raw = !(490 ≤ vc < 492).
  - Both are registered twice, so hs/vs lag blank/rom_address by exactly one cycle, matching the downstream RGB register.
- Reset, asynchronous and allowed at any point mid-frame:
  - hc = vc = 0, row_base = 0, scroll_q = 0.
  - hs = vs = 1, blank = 0, drawX = drawY = 0, rom_address = 0, frame_start = 0.
  - On release, the first output cycle is pixel (0,0) with frame_start = 1.

## Timing
- Latency:
  - Counter to drawX/drawY/blank/rom_address/frame_start: 1 cycle.
  - Counter to hs/vs: 2 cycles.
- ROM address is stable for a full clock. The downstream ROM samples on negedge, so data is valid before the next posedge.
- Frame period: 800 × 525 = 420 000 clocks; frame_start period identical.
- No stalls or handshake; free-running.

## Structure
- Package vga_timing_pkg holds:
  - the H/V timing constants;
  - derived totals H_TOTAL = 800 and V_TOTAL = 525;
  - sync start/end values;
  - IMG_W, IMG_H and SCALE_SHIFT.
- Sub-module vga_counter holds the hc/vc counters, wrap flags and raw syncs. back_scan_gen adds the scroll latch, address arithmetic and output/sync-delay registers.

## Test plan
- Reset held, then released. Required: first output cycle drawX=0, drawY=0, blank=1, frame_start=1, rom_address=0. During reset hs=vs=1 and blank=0.
- Line timing, scroll 0:
  - drawX=639 → blank=1, rom_address=159.
  - drawX=640 → blank=0, rom_address=0.
  - hs low for exactly 96 cycles, starting one cycle after drawX=656.
- Addressing:
  - (x=4, y=4) → 161.
  - (x=639, y=479) → 19199.
  - Every line y=476..479 repeats row base 19040.
- Scroll wrap: scroll_x=150 latched at frame start. Required: x=0 → 150, x=36 → 159, x=40 → 0 (wrap), x=639 → 149 on line 0.
- Scroll timing and illegal values:
  - scroll_x changed mid-frame → no change until the next frame_start.
  - scroll_x=200 → previous offset retained.
- Frame boundaries: count 420 000 clocks between frame_start pulses. vs low for exactly 1600 cycles. Assert reset at (x=300, y=200), then release. Required: restart at (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and background image geometry.
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks
  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FP      = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BP      = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing, in lines
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FP      = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BP      = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525

  // Sync windows: [start, end)
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;      // 656
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC; // 752
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;      // 490
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC; // 492

  // Background image: 160x120 texels, each texel is 4x4 screen pixels
  localparam logic [8:0]  IMG_W       = 9'd160;
  localparam logic [8:0]  IMG_H       = 9'd120;
  localparam int unsigned SCALE_SHIFT = 2;
  localparam int unsigned ADDR_W      = 15;

endpackage

// File: rtl/vga_counter.sv
// Free-running horizontal/vertical scan counters with wrap flags and raw syncs.
module vga_counter
  import vga_timing_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [9:0] hc_o,
  output logic [9:0] vc_o,
  output logic       h_wrap_o,
  output logic       frame_wrap_o,
  output logic       hs_raw_o,
  output logic       vs_raw_o
);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       h_last, v_last;

  // Next-state counters, wrap flags and active-low raw syncs
  always_comb begin
    h_last = (hc_q == H_TOTAL - 10'd1);
    v_last = (vc_q == V_TOTAL - 10'd1);
    hc_d   = h_last ? 10'd0 : hc_q + 10'd1;
    vc_d   = vc_q;
    if (h_last) begin
      vc_d = v_last ? 10'd0 : vc_q + 10'd1;
    end
    hs_raw_o = !((hc_q >= H_SYNC_START) && (hc_q < H_SYNC_END));
    vs_raw_o = !((vc_q >= V_SYNC_START) && (vc_q < V_SYNC_END));
  end

  // Counter state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hc_q <= 10'd0;
      vc_q <= 10'd0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc_o         = hc_q;
  assign vc_o         = vc_q;
  assign h_wrap_o     = h_last;
  assign frame_wrap_o = h_last && v_last;

endmodule

// File: rtl/back_scan_gen.sv
// Scan generator feeding the background colour stage: registered coordinates,
// blank, scrolled background ROM address, and syncs delayed one extra cycle.
module back_scan_gen
  import vga_timing_pkg::*;
(
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [7:0]        scroll_x,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic [9:0]        drawX,
  output logic [9:0]        drawY,
  output logic [ADDR_W-1:0] rom_address,
  output logic              frame_start
);

  logic [9:0] hc, vc;
  logic       h_wrap, frame_wrap, hs_raw, vs_raw;

  vga_counter u_counter (
    .clk_i        (vga_clk),
    .rst_i        (reset),
    .hc_o         (hc),
    .vc_o         (vc),
    .h_wrap_o     (h_wrap),
    .frame_wrap_o (frame_wrap),
    .hs_raw_o     (hs_raw),
    .vs_raw_o     (vs_raw)
  );

  logic [7:0]        scroll_q, scroll_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              blank_q, blank_d;
  logic [9:0]        drawx_q, drawy_q;
  logic [ADDR_W-1:0] rom_q, rom_d;
  logic              fs_q, fs_d;
  logic              hs_d1_q, hs_q, vs_d1_q, vs_q;

  logic [8:0]        col_sum, col;
  logic              visible;

  // Scroll latch, row base accumulation and address/blank next-state
  always_comb begin
    scroll_d = scroll_q;
    // Out-of-range offsets are ignored so the column wrap stays a single subtract
    if (frame_wrap && ({1'b0, scroll_x} < IMG_W)) begin
      scroll_d = scroll_x;
    end

    row_base_d = row_base_q;
    if (frame_wrap) begin
      row_base_d = '0;
    end else if (h_wrap && (vc[1:0] == 2'b11) && (vc < V_VISIBLE - 10'd1)) begin
      row_base_d = row_base_q + {6'd0, IMG_W};
    end

    col_sum = {1'b0, hc[9:SCALE_SHIFT]} + {1'b0, scroll_q};
    col     = (col_sum >= IMG_W) ? col_sum - IMG_W : col_sum;

    visible = (hc < H_VISIBLE) && (vc < V_VISIBLE);
    blank_d = visible;
    rom_d   = visible ? row_base_q + {6'd0, col} : '0;
    fs_d    = (hc == 10'd0) && (vc == 10'd0);
  end

  // Scroll and row-base state
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      scroll_q   <= 8'd0;
      row_base_q <= '0;
    end else begin
      scroll_q   <= scroll_d;
      row_base_q <= row_base_d;
    end
  end

  // Output registers; syncs get a second stage to line up with downstream RGB
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank_q <= 1'b0;
      drawx_q <= 10'd0;
      drawy_q <= 10'd0;
      rom_q   <= '0;
      fs_q    <= 1'b0;
      hs_d1_q <= 1'b1;
      hs_q    <= 1'b1;
      vs_d1_q <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      blank_q <= blank_d;
      drawx_q <= hc;
      drawy_q <= vc;
      rom_q   <= rom_d;
      fs_q    <= fs_d;
      hs_d1_q <= hs_raw;
      hs_q    <= hs_d1_q;
      vs_d1_q <= vs_raw;
      vs_q    <= vs_d1_q;
    end
  end

  assign blank       = blank_q;
  assign drawX       = drawx_q;
  assign drawY       = drawy_q;
  assign rom_address = rom_q;
  assign frame_start = fs_q;
  assign hs          = hs_q;
  assign vs          = vs_q;

endmodule

// File: tb/tb_back_scan_gen.sv
// Scoreboard bench for back_scan_gen: expected pixels are queued by the stimulus
// process and matched by a monitor when the DUT reaches that coordinate.
module tb_back_scan_gen;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  scroll_x = 8'd0;
  logic        hs, vs, blank, frame_start;
  logic [9:0]  drawX, drawY;
  logic [14:0] rom_address;

  back_scan_gen dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .scroll_x    (scroll_x),
    .hs          (hs),
    .vs          (vs),
    .blank       (blank),
    .drawX       (drawX),
    .drawY       (drawY),
    .rom_address (rom_address),
    .frame_start (frame_start)
  );

  always #20 vga_clk = ~vga_clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int x;
    int y;
    int blank;
    int addr;
    int fs;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  exp_t  mon_e;
  string mon_n;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push(input string name, input int x, input int y, input int b,
                      input int addr, input int fs);
    exp_t e;
    e.x = x; e.y = y; e.blank = b; e.addr = addr; e.fs = fs;
    sb_q.push_back(e);
    nm_q.push_back(name);
  endtask

  // Wait until the monitor has consumed every queued expectation
  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 450000) begin
      @(negedge vga_clk);
      n++;
    end
    check({name, ".drained"}, sb_q.size(), 0);
    sb_q.delete();
    nm_q.delete();
  endtask

  // Monitor: compare when the DUT presents the queued coordinate
  always @(negedge vga_clk) begin
    if (!reset && sb_q.size() > 0) begin
      if (int'(drawX) == sb_q[0].x && int'(drawY) == sb_q[0].y) begin
        mon_e = sb_q.pop_front();
        mon_n = nm_q.pop_front();
        check({mon_n, ".blank"}, int'(blank), mon_e.blank);
        check({mon_n, ".addr"}, int'(rom_address), mon_e.addr);
        check({mon_n, ".frame_start"}, int'(frame_start), mon_e.fs);
      end
    end
  end

  // hs pulse: first low cycle follows drawX=656, width 96
  logic hs_prev = 1'b1;
  int   hs_run = 0, hs_checks = 0, hs_px = 0;
  always @(negedge vga_clk) begin
    if (reset) begin
      hs_prev = 1'b1;
      hs_run  = 0;
    end else begin
      if (hs_prev && !hs) begin
        if (hs_checks < 2) check("hs_start_prev_drawX", hs_px, 656);
        hs_run = 1;
      end else if (!hs) begin
        hs_run++;
      end else if (!hs_prev && hs) begin
        if (hs_checks < 2) begin
          check("hs_low_width", hs_run, 96);
          hs_checks++;
        end
      end
      hs_prev = hs;
      hs_px   = int'(drawX);
    end
  end

  // vs pulse: falls on line 490, width 1600
  logic vs_prev = 1'b1;
  int   vs_run = 0, vs_checks = 0;
  always @(negedge vga_clk) begin
    if (reset) begin
      vs_prev = 1'b1;
      vs_run  = 0;
    end else begin
      if (vs_prev && !vs) begin
        if (vs_checks < 2) check("vs_start_drawY", int'(drawY), 490);
        vs_run = 1;
      end else if (!vs) begin
        vs_run++;
      end else if (!vs_prev && vs) begin
        if (vs_checks < 2) begin
          check("vs_low_width", vs_run, 1600);
          vs_checks++;
        end
      end
      vs_prev = vs;
    end
  end

  // Frame period between consecutive frame_start pulses
  bit fp_armed = 1'b0;
  int fp_cnt = 0, fp_checks = 0;
  always @(negedge vga_clk) begin
    if (reset) begin
      fp_armed = 1'b0;
      fp_cnt   = 0;
    end else begin
      fp_cnt++;
      if (frame_start) begin
        if (fp_armed && fp_checks < 2) begin
          check("frame_period", fp_cnt, 420000);
          fp_checks++;
        end
        fp_armed = 1'b1;
        fp_cnt   = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, ".hs"}, int'(hs), 1);
    check({name, ".vs"}, int'(vs), 1);
    check({name, ".blank"}, int'(blank), 0);
    check({name, ".frame_start"}, int'(frame_start), 0);
    check({name, ".addr"}, int'(rom_address), 0);
    check({name, ".drawX"}, int'(drawX), 0);
    check({name, ".drawY"}, int'(drawY), 0);
  endtask

  initial begin
    int n;
    repeat (5) @(negedge vga_clk);
    check_reset_outputs("in_reset");

    // Frame 1, scroll 0
    push("f1_px0_0", 0, 0, 1, 0, 1);
    push("f1_px639_0", 639, 0, 1, 159, 0);
    push("f1_px640_0", 640, 0, 0, 0, 0);
    push("f1_px4_4", 4, 4, 1, 161, 0);
    push("f1_px0_476", 0, 476, 1, 19040, 0);
    push("f1_px0_477", 0, 477, 1, 19040, 0);
    push("f1_px0_478", 0, 478, 1, 19040, 0);
    push("f1_px0_479", 0, 479, 1, 19040, 0);
    push("f1_px639_479", 639, 479, 1, 19199, 0);
    push("f1_px0_480", 0, 480, 0, 0, 0);
    @(negedge vga_clk);
    #2 reset = 1'b0;
    drain("frame1");

    // Frame 2 picks up offset 150
    scroll_x = 8'd150;
    push("f2_px0_0", 0, 0, 1, 150, 1);
    push("f2_px36_0", 36, 0, 1, 159, 0);
    push("f2_px40_0", 40, 0, 1, 0, 0);
    push("f2_px639_0", 639, 0, 1, 149, 0);
    drain("frame2_line0");

    // Mid-frame change (and an out-of-range value) must not disturb the offset
    scroll_x = 8'd200;
    push("f2_px0_2", 0, 2, 1, 150, 0);
    push("f2_px4_4", 4, 4, 1, 311, 0);
    drain("frame2_midframe");

    // Frame 3 keeps 150 because 200 is out of range
    push("f3_px0_0", 0, 0, 1, 150, 1);
    push("f3_px40_0", 40, 0, 1, 0, 0);
    drain("frame3");

    // Asynchronous reset mid-frame at (300,200)
    n = 0;
    while (!(drawX == 10'd300 && drawY == 10'd200) && n < 450000) begin
      @(negedge vga_clk);
      n++;
    end
    check("reached_300_200", int'(drawX == 10'd300 && drawY == 10'd200), 1);
    reset = 1'b1;
    #5;
    check_reset_outputs("midframe_reset");
    repeat (3) @(negedge vga_clk);
    scroll_x = 8'd0;
    push("rst_px0_0", 0, 0, 1, 0, 1);
    push("rst_px639_0", 639, 0, 1, 159, 0);
    #2 reset = 1'b0;
    drain("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
